// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared sizing constants for the SRAM2S stream FIFO
package sram_fifo_pkg;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int LW = 14;
  localparam int DEPTH = 2 ** AW;
  localparam logic [DW-1:0] WEM_ALL = '1;
endpackage

// File: rtl/sram2s_fifo_obuf.sv
// sram2s_fifo_obuf: 2-entry output buffer (clk, rst_n, clr, push/push_data, pop -> valid, head, cnt)
module sram2s_fifo_obuf #(
  parameter int DW = sram_fifo_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] head,
  output logic [1:0]    cnt
);
  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          hd_q, hd_d;
  logic [1:0]    cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[hd_q ^ cnt_q[0]] = push_data;
    if (clr) mem_d = '{default: '0};
    hd_d = clr ? 1'b0 : hd_q ^ pop;
    cnt_d = clr ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '{default: '0};
      hd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      hd_q <= hd_d;
      cnt_q <= cnt_d;
    end
  assign valid = cnt_q != 2'd0;
  assign head = mem_q[hd_q];
  assign cnt = cnt_q;
endmodule

// File: rtl/sram2s_stream_fifo.sv
// sram2s_stream_fifo: valid/ready stream FIFO over a 2-port SRAM (port 0 write, port 1 read) with 2-entry output buffer
module sram2s_stream_fifo #(
  parameter int AW = sram_fifo_pkg::AW,
  parameter int DW = sram_fifo_pkg::DW,
  parameter int LW = sram_fifo_pkg::LW
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [LW-1:0] level,
  output logic          sram_ce0,
  output logic [AW-1:0] sram_a0,
  output logic [DW-1:0] sram_d0,
  output logic          sram_we0,
  output logic [DW-1:0] sram_wem0,
  output logic          sram_ce1,
  output logic [AW-1:0] sram_a1,
  output logic          sram_we1,
  input  logic [DW-1:0] sram_q1
);
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   mem_cnt_q, mem_cnt_d;
  logic [LW-1:0] level_q, level_d;
  logic          rd_pend_q, rd_pend_d, in_ready_q, in_ready_d;
  logic [1:0]    obuf_cnt;
  logic          push, pop, issue;
  always_comb begin
    push = in_valid && in_ready_q && !flush;
    pop = out_valid && out_ready && !flush;
    issue = !flush && (mem_cnt_q != '0) && ({1'b0, obuf_cnt} + {2'b0, rd_pend_q} - {2'b0, pop} < 3'd2);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(issue);
    mem_cnt_d = flush ? '0 : mem_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
    rd_pend_d = issue;
    in_ready_d = mem_cnt_d < FULL;
    level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      in_ready_q <= 1'b0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      rd_pend_q <= rd_pend_d;
      in_ready_q <= in_ready_d;
      level_q <= level_d;
    end
  sram2s_fifo_obuf #(.DW(DW)) u_obuf (
    .clk      (CLK),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (rd_pend_q && !flush),
    .push_data(sram_q1),
    .pop      (pop),
    .valid    (out_valid),
    .head     (out_data),
    .cnt      (obuf_cnt)
  );
  assign in_ready = in_ready_q;
  assign level = level_q;
  assign sram_ce0 = push;
  assign sram_we0 = push;
  assign sram_a0 = wr_ptr_q;
  assign sram_d0 = in_data;
  assign sram_wem0 = '1;
  assign sram_ce1 = issue;
  assign sram_a1 = rd_ptr_q;
  assign sram_we1 = 1'b0;
endmodule

// File: tb/tb_sram2s_stream_fifo.sv
// tb_sram2s_stream_fifo: directed self-checking bench with an SRAM model and a word scoreboard
module tb_sram2s_stream_fifo;
  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, sram_ce0, sram_we0, sram_ce1, sram_we1;
  logic [15:0] out_data, sram_d0, sram_wem0, sram_q1;
  logic [13:0] level;
  logic [12:0] sram_a0, sram_a1;
  logic [15:0] mem [8192];
  logic        collide = 1'b0;
  logic [15:0] q [$];
  int          n_chk = 0, n_fail = 0, pushed = 0, popped = 0, guard = 0;

  sram2s_stream_fifo dut (
    .CLK(CLK), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .sram_ce0(sram_ce0), .sram_a0(sram_a0), .sram_d0(sram_d0), .sram_we0(sram_we0), .sram_wem0(sram_wem0),
    .sram_ce1(sram_ce1), .sram_a1(sram_a1), .sram_we1(sram_we1), .sram_q1(sram_q1)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (sram_ce0 && sram_we0) mem[sram_a0] <= sram_d0 & sram_wem0;
    sram_q1 <= sram_ce1 ? mem[sram_a1] : 16'hxxxx;
    if (sram_ce0 && sram_ce1 && sram_a0 == sram_a1) collide <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic iv, input logic [15:0] id, input logic ordy);
    in_valid = iv;
    in_data = id;
    out_ready = ordy;
    @(negedge CLK);
    if (in_valid && in_ready) begin
      q.push_back(in_data);
      pushed++;
    end
    if (out_valid && out_ready) begin
      popped++;
      if (q.size() == 0) chk("out_without_push", 32'(q.size() != 0), 32'd1);
      else chk("out_data_order", 32'(out_data), 32'(q.pop_front()));
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_ce0", 32'(sram_ce0), 0);
    chk("rst_ce1", 32'(sram_ce1), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_level", 32'(level), 0);
    #10 rst_n = 1'b1;
    #1 chk("in_ready_before_edge", 32'(in_ready), 0);
    @(posedge CLK); #1;
    chk("in_ready_after_edge", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
    @(negedge CLK);
    chk("push_ce0", 32'(sram_ce0), 1);
    chk("push_we0", 32'(sram_we0), 1);
    chk("push_a0", 32'(sram_a0), 0);
    chk("push_d0", 32'(sram_d0), 32'h1234);
    chk("push_wem0", 32'(sram_wem0), 32'hffff);
    chk("push_we1", 32'(sram_we1), 0);
    chk("push_no_issue", 32'(sram_ce1), 0);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("issue_ce1", 32'(sram_ce1), 1);
    chk("issue_a1", 32'(sram_a1), 0);
    chk("issue_ce0", 32'(sram_ce0), 0);
    chk("issue_level", 32'(level), 1);
    chk("issue_out_valid", 32'(out_valid), 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("capture_out_valid", 32'(out_valid), 0);
    chk("capture_level", 32'(level), 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("first_out_valid", 32'(out_valid), 1);
    chk("first_out_data", 32'(out_data), 32'h1234);
    chk("first_level", 32'(level), 1);
    @(posedge CLK); #1;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    chk("pop_level", 32'(level), 0);
    chk("pop_out_valid", 32'(out_valid), 0);

    pushed = 0; popped = 0;
    for (int i = 0; i < 100; i++) cyc(1'b1, 16'(i), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1);
    chk("stream_pushed", 32'(pushed), 100);
    chk("stream_popped", 32'(popped), 100);
    chk("stream_level", 32'(level), 0);

    pushed = 0; popped = 0; guard = 0;
    while (in_ready && guard < 8400) begin
      cyc(1'b1, 16'(pushed), 1'b0);
      guard++;
    end
    chk("fill_accepted", 32'(pushed), 8194);
    chk("fill_level", 32'(level), 8194);
    chk("fill_in_ready", 32'(in_ready), 0);
    @(negedge CLK);
    chk("fill_no_write", 32'(sram_ce0), 0);
    @(posedge CLK); #1;
    cyc(1'b0, 16'h0, 1'b1);
    chk("fill_pop_once", 32'(popped), 1);
    chk("fill_ready_back", 32'(in_ready), 1);
    chk("fill_level_after_pop", 32'(level), 8193);
    guard = 0;
    while (q.size() > 0 && guard < 8400) begin
      cyc(1'b0, 16'h0, 1'b1);
      guard++;
    end
    chk("fill_drained", 32'(q.size()), 0);
    chk("fill_drain_level", 32'(level), 0);

    pushed = 0; popped = 0; guard = 0;
    while ((pushed < 10000 || q.size() > 0) && guard < 60000) begin
      cyc(pushed < 10000 && $urandom_range(3) != 0, 16'($urandom), 1'($urandom_range(1)));
      guard++;
    end
    chk("wrap_pushed", 32'(pushed), 10000);
    chk("wrap_popped", 32'(popped), 10000);
    chk("wrap_level", 32'(level), 0);
    chk("wrap_no_collision", 32'(collide), 0);

    q.delete();
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'hA000 + 16'(i), 1'b0);
    chk("preflush_out_valid", 32'(out_valid), 1);
    chk("preflush_level", 32'(level), 3);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h5555;
    @(posedge CLK); #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_level", 32'(level), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_out_data", 32'(out_data), 0);
    popped = 0;
    cyc(1'b1, 16'hBEEF, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1);
    chk("flush_one_out", 32'(popped), 1);
    chk("flush_q_empty", 32'(q.size()), 0);

    q.delete();
    for (int i = 0; i < 6; i++) cyc(1'b1, 16'h7000 + 16'(i), 1'b1);
    chk("midrst_pre_ce0", 32'(sram_ce0), 1);
    chk("midrst_pre_ce1", 32'(sram_ce1), 1);
    chk("midrst_pre_out_valid", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_ce0", 32'(sram_ce0), 0);
    chk("midrst_ce1", 32'(sram_ce1), 0);
    chk("midrst_level", 32'(level), 0);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge CLK); #1;
    rst_n = 1'b1;
    @(posedge CLK); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram2s_stream_fifo.md
Name: sram2s_stream_fifo

Overview:
Streaming FIFO controller that owns both ports of an external SRAM2S_8192X16 instance. Port 0 is write-only and port 1 is read-only. It turns a valid/ready input stream into SRAM writes, and SRAM reads into a valid/ready output stream. A 2-entry output buffer absorbs the 1-cycle SRAM read latency. It sits directly upstream of the SRAM, buffering visible/hidden unit data between RBM compute stages.

Parameters:
AW, 13, SRAM address width (depth = 2**AW = 8192)
DW, 16, data width (must match SRAM word)
LW, 14, level counter width (must hold 2**AW+2)

Ports:
CLK  in  1  clock; all state on posedge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of FIFO contents
in_valid  in  1  producer has a word
in_ready  out  1  FIFO accepts a word this cycle
in_data  in  DW  producer word
out_valid  out  1  out_data holds a valid word
out_ready  in  1  consumer takes the word
out_data  out  DW  head word
level  out  LW  words accepted and not yet popped
sram_ce0  out  1  SRAM port 0 enable
sram_a0  out  AW  SRAM port 0 address
sram_d0  out  DW  SRAM port 0 write data
sram_we0  out  1  SRAM port 0 write enable
sram_wem0  out  DW  SRAM port 0 write mask; constant all-ones
sram_ce1  out  1  SRAM port 1 enable
sram_a1  out  AW  SRAM port 1 address
sram_we1  out  1  SRAM port 1 write enable; constant 0
sram_q1  in  DW  SRAM port 1 read data, valid the cycle after a read is issued

Behaviour:
- One clock, CLK. Reset rst_n is asynchronous and active-low.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, mem_cnt = 0, rd_pend = 0, obuf_cnt = 0, level = 0.
  - out_valid = 0, in_ready = 0, sram_ce0 = 0, sram_ce1 = 0, out_data = 0.
- in_ready is a register equal to (mem_cnt_next < 2**AW). It first rises at the first edge after rst_n deasserts.
- Push (in_valid && in_ready):
  - sram_ce0 = sram_we0 = 1, sram_a0 = wr_ptr, sram_d0 = in_data, driven combinationally in the same cycle.
  - wr_ptr increments mod 2**AW, with natural wrap 8191 -> 0.
- Read issue, same cycle, when mem_cnt > 0 and (obuf_cnt + rd_pend) < 2 after accounting for this cycle's pop:
  - sram_ce1 = 1, sram_a1 = rd_ptr.
  - rd_ptr increments mod 2**AW.
  - rd_pend is set to 1 for the next cycle.
- Capture: when rd_pend = 1, sram_q1 is written into the output buffer tail. sram_q1 is never sampled when rd_pend = 0, because Q1 is X when CE1 is low.
- mem_cnt counts written-but-not-issued words and only counts words written at an earlier edge. This guarantees no same-address read/write in one cycle.
- mem_cnt_next = mem_cnt + push - issue.
- Output buffer:
  - 2-entry FIFO; out_valid = (obuf_cnt != 0); out_data = head entry.
  - A pop (out_valid && out_ready) frees a slot in the same cycle for issue accounting.
- Latency:
  - A word pushed at edge k is read-issued at edge k+1 (if the buffer has room) and captured at edge k+2.
  - out_valid is high in the cycle after edge k+2.
  - With out_ready held high, sustained throughput is 1 word/cycle.
- level = mem_cnt + rd_pend + obuf_cnt, updated every edge, maximum 2**AW + 2.
- Full: mem_cnt = 8192 -> in_ready = 0. A push and a pop in the same cycle at full is not possible, because in_ready is registered low. in_ready returns next cycle after an issue.
- Empty: no issue and no out_valid. A push into an empty FIFO never bypasses the SRAM.
- Flush (synchronous, takes priority over push, issue and pop in the same cycle):
  - Zeroes pointers, counts and obuf. The in-flight sram_q1 of the next cycle is discarded.
  - in_ready stays 1. Outputs are as at reset, except in_ready.
- Reset mid-operation: all state clears immediately. In-flight reads and SRAM contents are disregarded.

Decomposition:
- Shared package sram_fifo_pkg: constants AW, DW, LW, DEPTH = 2**AW, and WEM_ALL = all-ones mask.
- One sub-module, sram2s_fifo_obuf: the 2-entry output buffer (push, pop, count, head). Top level keeps the pointers, counters and SRAM port drive.

Test Plan:
- Reset release then push 0x1234 at edge 3 with out_ready = 0:
  - sram_ce0/we0 = 1, a0 = 0 in that cycle; sram_ce1 = 1, a1 = 0 the next cycle.
  - out_valid = 1, out_data = 0x1234 two cycles after the push; level = 1 throughout.
- Stream 100 words 0..99 with out_ready = 1 continuously: output identical in order, 1 word/cycle after a 2-cycle initial latency, level returns to 0.
- Fill with out_ready = 0:
  - 8194 words accepted (8192 in SRAM + 2 in obuf), then in_ready = 0 and level = 8194.
  - Pop one -> in_ready = 1 within 2 cycles.
- Wrap: push/pop 10000 words with random out_ready: data order is correct across the wr_ptr/rd_ptr 8191->0 wrap, and there are no sram_a0 == sram_a1 same-cycle accesses with both enables high.
- Flush with obuf full and a read in flight: next cycle out_valid = 0 and level = 0. The in-flight word never appears, and the next pushed word 0xBEEF is the first output.
- Assert rst_n = 0 asynchronously mid-stream: out_valid, in_ready, sram_ce0 and sram_ce1 drop to 0 immediately without a clock edge, and level reads 0.
